// File: rtl/f8_romc_mem.sv
// F8 program-storage responder: decodes the ROMC code of each machine cycle, keeps PC0/PC1/DC0/DC1
// and turns memory references into a request/ready handshake toward the SRAM controller.
module f8_romc_mem #(
   parameter logic [15:0] RESET_PC = 16'h0000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [4:0]  romc,
   input  logic        write,
   input  logic [7:0]  db_in,
   output logic [7:0]  db_out,
   output logic        db_t,
   output logic [15:0] mem_addr,
   output logic        mem_rd,
   output logic        mem_wr,
   output logic [7:0]  mem_wdata,
   input  logic [7:0]  mem_rdata,
   input  logic        mem_ready,
   output logic        late
);

   typedef enum logic [2:0] {S_IDLE, S_READ, S_DRIVE, S_WAIT, S_WPEND} state_t;

   state_t      state, state_nxt;
   logic        write_q, cs, commit, cs_pend, start, update;
   logic [4:0]  code, start_code;
   logic [15:0] pc0, pc1, dc0, dc1, start_addr;
   logic [7:0]  start_drive;

   function automatic logic is_mem_rd(input logic [4:0] c);
      case (c)
         5'h00, 5'h01, 5'h02, 5'h03, 5'h0C, 5'h0E, 5'h11: return 1'b1;
         default: return 1'b0;
      endcase
   endfunction

   function automatic logic is_reg_rd(input logic [4:0] c);
      case (c)
         5'h06, 5'h07, 5'h09, 5'h0B, 5'h1E, 5'h1F: return 1'b1;
         default: return 1'b0;
      endcase
   endfunction

   function automatic state_t enter(input logic [4:0] c);
      if (is_mem_rd(c))      return S_READ;
      else if (is_reg_rd(c)) return S_DRIVE;
      else                   return S_WAIT;
   endfunction

   function automatic logic signed [15:0] sext(input logic signed [7:0] b);
      return 16'(b);
   endfunction

   always_ff @(posedge clk) write_q <= write;

   assign cs     = write_q & ~write;
   assign commit = ~write_q & write;

   always_ff @(posedge clk) begin
      if (rst) state <= S_IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE:  if (cs) state_nxt = enter(romc);
         S_READ:  if (commit) state_nxt = S_IDLE;
                  else if (mem_ready) state_nxt = S_DRIVE;
         S_DRIVE: if (commit) state_nxt = S_IDLE;
         S_WAIT:  if (commit) state_nxt = (code == 5'h05) ? S_WPEND : S_IDLE;
         S_WPEND: if (mem_ready) state_nxt = (cs_pend || cs) ? enter(start_code) : S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
   end

   // A cycle start that arrived during a pending write is replayed with the latched code.
   always_comb begin
      start_code  = (state == S_WPEND && cs_pend) ? code : romc;
      start       = (state == S_IDLE && cs) || (state == S_WPEND && mem_ready && (cs_pend || cs));
      update      = commit && (state == S_READ || state == S_DRIVE || state == S_WAIT);
      start_addr  = (start_code == 5'h02) ? dc0 : pc0;
      start_drive = 8'h00;
      case (start_code)
         5'h06:   start_drive = dc0[15:8];
         5'h09:   start_drive = dc0[7:0];
         5'h07:   start_drive = pc1[15:8];
         5'h0B:   start_drive = pc1[7:0];
         5'h1E:   start_drive = pc0[7:0];
         5'h1F:   start_drive = pc0[15:8];
         default: start_drive = 8'h00;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         pc0 <= RESET_PC; pc1 <= RESET_PC; dc0 <= RESET_PC; dc1 <= RESET_PC;
         db_out <= 8'h00; db_t <= 1'b1;
         mem_rd <= 1'b0; mem_wr <= 1'b0; mem_addr <= 16'h0000; mem_wdata <= 8'h00;
         late <= 1'b0; code <= 5'h00; cs_pend <= 1'b0;
      end else begin
         if (start) begin
            code    <= start_code;
            cs_pend <= 1'b0;
            db_t    <= 1'b1;
            if (is_mem_rd(start_code)) begin
               mem_rd   <= 1'b1;
               mem_addr <= start_addr;
            end else if (is_reg_rd(start_code)) begin
               db_out <= start_drive;
               db_t   <= 1'b0;
            end
         end else if (state == S_WPEND && cs) begin
            code    <= romc;
            cs_pend <= 1'b1;
         end
         if (state == S_READ) begin
            if (mem_ready) begin
               db_out <= mem_rdata;
               db_t   <= 1'b0;
               mem_rd <= 1'b0;
            end else if (commit) begin
               late   <= 1'b1;
               mem_rd <= 1'b0;
            end
         end
         if (state == S_WPEND && mem_ready) mem_wr <= 1'b0;
         // Commit: the bus is released and the code's register update applied with db_in.
         if (update) begin
            db_t <= 1'b1;
            case (code)
               5'h00, 5'h03: pc0 <= pc0 + 16'h0001;
               5'h01:        pc0 <= pc0 + $unsigned(sext(db_in));
               5'h02:        dc0 <= dc0 + 16'h0001;
               5'h04:        pc0 <= pc1;
               5'h05: begin
                  dc0       <= dc0 + 16'h0001;
                  mem_wr    <= 1'b1;
                  mem_addr  <= dc0;
                  mem_wdata <= db_in;
               end
               5'h08: begin
                  pc1 <= pc0;
                  pc0 <= {db_in, db_in};
               end
               5'h0A:        dc0 <= dc0 + $unsigned(sext(db_in));
               5'h0C, 5'h17: pc0[7:0] <= db_in;
               5'h0D:        pc1 <= pc0 + 16'h0001;
               5'h0E, 5'h19: dc0[7:0] <= db_in;
               5'h11, 5'h16: dc0[15:8] <= db_in;
               5'h0F, 5'h12: begin
                  pc1      <= pc0;
                  pc0[7:0] <= db_in;
               end
               5'h13, 5'h14: pc0[15:8] <= db_in;
               5'h15:        pc1[15:8] <= db_in;
               5'h18:        pc1[7:0] <= db_in;
               5'h1D: begin
                  dc0 <= dc1;
                  dc1 <= dc0;
               end
               default: ;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_f8_romc_mem.sv
// Directed bench for f8_romc_mem: F8 machine cycles with a looped-back data bus and a
// delay-programmable memory responder.
module tb_f8_romc_mem;

   logic        clk = 1'b0;
   logic        rst, write;
   logic [4:0]  romc;
   logic [7:0]  db_in, db_out, mem_wdata, bus_drv;
   logic        db_t, mem_rd, mem_wr, late;
   logic [15:0] mem_addr;
   logic [7:0]  mem_rdata = 8'h00;
   logic        mem_ready = 1'b0;

   int          n_chk = 0;
   int          n_err = 0;

   // memory responder controls and log
   int          rdy_dly = 3;
   logic        hold = 1'b0;
   logic [7:0]  mem_byte = 8'h00;
   int          cnt = 0;
   logic        rd_prev = 1'b0, wr_prev = 1'b0;
   logic [15:0] rd_addrs[$];
   logic [15:0] wr_addr = 16'h0;
   logic [7:0]  wr_data = 8'h0;
   int          wr_cnt = 0;
   int          overlap = 0;

   // per-cycle samples
   logic        early_db_t, early_rd, smp_db_t, post_db_t;
   logic [7:0]  smp_db_out;
   logic [15:0] v;

   always #5 clk = ~clk;

   // The CPU sees our own drive on the pins whenever we are not tristated.
   assign db_in = db_t ? bus_drv : db_out;

   f8_romc_mem dut (
      .clk(clk), .rst(rst), .romc(romc), .write(write),
      .db_in(db_in), .db_out(db_out), .db_t(db_t),
      .mem_addr(mem_addr), .mem_rd(mem_rd), .mem_wr(mem_wr),
      .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready),
      .late(late)
   );

   always @(negedge clk) begin
      if (mem_rd && !rd_prev) rd_addrs.push_back(mem_addr);
      if (mem_wr && !wr_prev) begin
         wr_addr = mem_addr;
         wr_data = mem_wdata;
         wr_cnt++;
      end
      if (mem_rd && mem_wr) overlap++;
      rd_prev = mem_rd;
      wr_prev = mem_wr;
      if (mem_ready) begin
         mem_ready = 1'b0;
         cnt = 0;
      end else if ((mem_rd || mem_wr) && !hold) begin
         cnt++;
         if (cnt >= rdy_dly) begin
            mem_ready = 1'b1;
            mem_rdata = mem_byte;
         end
      end else begin
         cnt = 0;
      end
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // One machine cycle: cs at the first posedge, commit len clocks later.
   task automatic mcycle(input logic [4:0] c, input logic [7:0] d, input int len);
      @(negedge clk);
      romc = c; bus_drv = d; write = 1'b0;
      @(negedge clk);
      early_db_t = db_t; early_rd = mem_rd;
      repeat (len - 1) @(negedge clk);
      smp_db_out = db_out; smp_db_t = db_t;
      write = 1'b1;
      @(negedge clk);
      post_db_t = db_t;
      @(negedge clk);
   endtask

   task automatic read16(input logic [4:0] hi, input logic [4:0] lo, output logic [15:0] r);
      mcycle(hi, 8'h00, 3);
      r[15:8] = smp_db_out;
      mcycle(lo, 8'h00, 3);
      r[7:0] = smp_db_out;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time %0t exceeded limit %0t", $time, 200000);
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1; write = 1'b1; romc = 5'h00; bus_drv = 8'h00;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      check("rst_db_t", db_t, 1'b1);
      check("rst_db_out", db_out, 8'h00);
      check("rst_mem_rd", mem_rd, 1'b0);
      check("rst_mem_wr", mem_wr, 1'b0);
      check("rst_mem_addr", mem_addr, 16'h0000);
      check("rst_late", late, 1'b0);

      // 08 loads PC0 from the bus, PC1 takes old PC0
      mcycle(5'h08, 8'h12, 3);
      mcycle(5'h1F, 8'h00, 3);
      check("1f_early_db_t", early_db_t, 1'b0);
      check("1f_db_out", smp_db_out, 8'h12);
      check("1f_release", post_db_t, 1'b1);
      mcycle(5'h1E, 8'h00, 3);
      check("1e_db_out", smp_db_out, 8'h12);
      read16(5'h07, 5'h0B, v);
      check("08_pc1", v, 16'h0000);

      // three 00 fetches from 00FF
      mcycle(5'h13, 8'h00, 3);
      mcycle(5'h17, 8'hFF, 3);
      rdy_dly = 3; mem_byte = 8'hA5; rd_addrs.delete();
      for (int i = 0; i < 3; i++) begin
         mcycle(5'h00, 8'h00, 6);
         check("00_early_rd", early_rd, 1'b1);
         check("00_db_out", smp_db_out, 8'hA5);
         check("00_db_t", smp_db_t, 1'b0);
      end
      check("00_nreads", rd_addrs.size(), 3);
      if (rd_addrs.size() == 3) begin
         check("00_addr0", rd_addrs[0], 16'h00FF);
         check("00_addr1", rd_addrs[1], 16'h0100);
         check("00_addr2", rd_addrs[2], 16'h0101);
      end
      read16(5'h1F, 5'h1E, v);
      check("00_pc0", v, 16'h0102);

      // 01 with negative relative offset
      mcycle(5'h13, 8'h00, 3);
      mcycle(5'h17, 8'h10, 3);
      mem_byte = 8'hFC;
      mcycle(5'h01, 8'h00, 6);
      read16(5'h1F, 5'h1E, v);
      check("01_pc0", v, 16'h000C);

      // ready and commit in the same clock: data taken, not late
      mem_byte = 8'h77;
      mcycle(5'h00, 8'h00, 3);
      check("same_late", late, 1'b0);
      check("same_db_out", db_out, 8'h77);
      read16(5'h1F, 5'h1E, v);
      check("same_pc0", v, 16'h000D);

      // 05 write, then 02 whose cycle start arrives while the write is pending
      mcycle(5'h16, 8'h20, 3);
      mcycle(5'h19, 8'h00, 3);
      rdy_dly = 4; mem_byte = 8'h33; rd_addrs.delete(); wr_cnt = 0; overlap = 0;
      mcycle(5'h05, 8'h5A, 2);
      mcycle(5'h02, 8'h00, 8);
      check("05_wr_cnt", wr_cnt, 1);
      check("05_wr_addr", wr_addr, 16'h2000);
      check("05_wr_data", wr_data, 8'h5A);
      check("05_overlap", overlap, 0);
      check("02_nreads", rd_addrs.size(), 1);
      if (rd_addrs.size() == 1) check("02_addr", rd_addrs[0], 16'h2001);
      check("02_db_out", smp_db_out, 8'h33);
      read16(5'h06, 5'h09, v);
      check("05_02_dc0", v, 16'h2002);

      // memory never answers: late read
      rdy_dly = 3;
      mcycle(5'h13, 8'h03, 3);
      mcycle(5'h17, 8'h00, 3);
      hold = 1'b1;
      mcycle(5'h00, 8'h00, 6);
      check("late_flag", late, 1'b1);
      check("late_rd_drop", mem_rd, 1'b0);
      check("late_release", post_db_t, 1'b1);
      hold = 1'b0;
      read16(5'h1F, 5'h1E, v);
      check("late_pc0", v, 16'h0301);
      check("late_sticky", late, 1'b1);

      // reset in the middle of a stalled read
      hold = 1'b1;
      @(negedge clk);
      romc = 5'h00; write = 1'b0;
      @(negedge clk);
      check("midrst_rd_before", mem_rd, 1'b1);
      rst = 1'b1; write = 1'b1;
      @(negedge clk);
      check("midrst_rd", mem_rd, 1'b0);
      check("midrst_late", late, 1'b0);
      rst = 1'b0; hold = 1'b0;
      @(negedge clk);
      read16(5'h1F, 5'h1E, v);
      check("midrst_pc0", v, 16'h0000);

      // DC0/DC1 swap
      mcycle(5'h16, 8'h12, 3);
      mcycle(5'h19, 8'h34, 3);
      mcycle(5'h1D, 8'h00, 3);
      check("swap1_dc1", dut.dc1, 16'h1234);
      read16(5'h06, 5'h09, v);
      check("swap1_dc0", v, 16'h0000);
      mcycle(5'h1D, 8'h00, 3);
      read16(5'h06, 5'h09, v);
      check("swap2_dc0", v, 16'h1234);

      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end

endmodule
